// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_ADDR_W  = 5;
    localparam int unsigned ZERO_ADDR   = 0;

    // Widest packed port bus / single slice the slice helper handles
    localparam int unsigned MAX_BUS_W   = 256;
    localparam int unsigned MAX_SLICE_W = 64;

    // Extract port k of width w from a packed bus; bits above w are cleared
    function automatic logic [MAX_SLICE_W-1:0] port_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          k,
        input int unsigned          w
    );
        logic [MAX_BUS_W-1:0]   shifted;
        logic [MAX_SLICE_W-1:0] res;
        shifted = bus >> (k * w);
        for (int unsigned i = 0; i < MAX_SLICE_W; i++) begin
            res[i] = (i < w) ? shifted[i] : 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for long-latency writebacks, with busy lookup per read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend;
    logic             set_ok;

    assign set_ok = pend_set && !((ZERO_REG != 0) && (pend_addr == ADDR_W'(ZERO_ADDR)));

    // Pending vector: completion clears, issue sets; the set is applied last so a new issue wins
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            if (wb_en) begin
                pend[wb_addr] <= 1'b0;
            end
            if (set_ok) begin
                pend[pend_addr] <= 1'b1;
            end
        end
    end

    // Busy lookup: registered pending state, masked when the completing data is forwarded
    always_comb begin
        logic [ADDR_W-1:0] a;
        rd_busy = '0;
        a       = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            a = ADDR_W'(port_slice(MAX_BUS_W'(rd_addr), k, ADDR_W));
            rd_busy[k] = pend[a];
            if ((ZERO_REG != 0) && (a == ADDR_W'(ZERO_ADDR))) begin
                rd_busy[k] = 1'b0;
            end
            if ((BYPASS != 0) && wb_en && (wb_addr == a)) begin
                rd_busy[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, combinational reads with optional bypass,
// optional hard-wired zero register and a pending-write scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wa_ok;
    logic              wb_ok;

    assign wa_ok = wa_en && !((ZERO_REG != 0) && (wa_addr == ADDR_W'(ZERO_ADDR)));
    assign wb_ok = wb_en && !((ZERO_REG != 0) && (wb_addr == ADDR_W'(ZERO_ADDR)));

    // Array update: port B first so port A overrides it on an address collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wb_ok) begin
                regs[wb_addr] <= wb_data;
            end
            if (wa_ok) begin
                regs[wa_addr] <= wa_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        localparam int unsigned K = k;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;

        assign a = ADDR_W'(port_slice(MAX_BUS_W'(rd_addr), K, ADDR_W));

        // Read mux: port A bypass, then port B bypass, then array; zero register forced to 0
        always_comb begin
            d = regs[a];
            if (BYPASS != 0) begin
                if (wa_ok && (wa_addr == a)) begin
                    d = wa_data;
                end else if (wb_ok && (wb_addr == a)) begin
                    d = wb_data;
                end
            end
            if ((ZERO_REG != 0) && (a == ADDR_W'(ZERO_ADDR))) begin
                d = '0;
            end
        end

        assign rd_data[K*DATA_W +: DATA_W] = d;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy)
    );

endmodule
